// File: rtl/gray_rx_pkg.sv
// Shared types and helpers for the Gray-code receive monitor.
// State encoding, count-direction codes and the Gray-to-binary bit helper.
package gray_rx_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        RESYNC   = 2'd1,
        TRACK    = 2'd2
    } state_t;

    localparam logic [1:0] DIR_HOLD    = 2'b00;
    localparam logic [1:0] DIR_UP      = 2'b01;
    localparam logic [1:0] DIR_DOWN    = 2'b10;
    localparam logic [1:0] DIR_ILLEGAL = 2'b11;

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    function automatic logic gray2bin_bit(
        input logic [31:0] g,
        input int          i
    );
        return ^(g >> i);
    endfunction

endpackage

// File: rtl/gray_rx_monitor_gray_to_bin.sv
// Combinational Gray-to-binary decoder used by gray_rx_monitor.
// Pure logic; registering is done by the instantiating block.
module gray_to_bin
    import gray_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    always_comb begin
        o_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_bin[i] = gray2bin_bit(32'(i_gray), i);
        end
    end

endmodule

// File: rtl/gray_rx_monitor.sv
// Gray stream receive monitor: decode, step legality, error count, lock.
// Optional input synchronizer enabled by defining GRAY_RX_SYNC_EN.
module gray_rx_monitor
    import gray_rx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8,
    parameter int LOCK_CNT  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     i_gray,
    input  logic                 i_valid,
    output logic [WIDTH-1:0]     o_bin,
    output logic                 o_bin_valid,
    output logic [1:0]           o_dir,
    output logic                 o_step_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic                 o_locked
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    logic [WIDTH-1:0] w_gray;
    logic             w_valid;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_delta;
    logic [1:0]       w_step_dir;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_bin;
    logic [WIDTH-1:0]     w_bin_nxt;
    logic                 r_bin_valid;
    logic                 w_bin_valid_nxt;
    logic [1:0]           r_dir;
    logic [1:0]           w_dir_nxt;
    logic                 r_step_err;
    logic                 w_step_err_nxt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
    logic [ERR_CNT_W-1:0] w_err_inc;
    logic [GW-1:0]        r_good;
    logic [GW-1:0]        w_good_nxt;

`ifdef GRAY_RX_SYNC_EN
    logic [WIDTH-1:0] r_gray_s1;
    logic [WIDTH-1:0] r_gray_s2;
    logic             r_valid_s1;
    logic             r_valid_s2;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_gray_s1  <= '0;
            r_gray_s2  <= '0;
            r_valid_s1 <= 1'b0;
            r_valid_s2 <= 1'b0;
        end else begin
            r_gray_s1  <= i_gray;
            r_gray_s2  <= r_gray_s1;
            r_valid_s1 <= i_valid;
            r_valid_s2 <= r_valid_s1;
        end
    end

    assign w_gray  = r_gray_s2;
    assign w_valid = r_valid_s2;
`else
    assign w_gray  = i_gray;
    assign w_valid = i_valid;
`endif

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_dec (
        .i_gray (w_gray),
        .o_bin  (w_bin)
    );

    // The last accepted sample is always held in r_bin, so it doubles as prev.
    assign w_delta = w_bin - r_bin;

    always_comb begin
        w_step_dir = DIR_ILLEGAL;
        unique case (1'b1)
            (w_delta == '0):        w_step_dir = DIR_HOLD;
            (w_delta == WIDTH'(1)): w_step_dir = DIR_UP;
            (w_delta == '1):        w_step_dir = DIR_DOWN;
            default:                w_step_dir = DIR_ILLEGAL;
        endcase
    end

    assign w_err_inc = (r_err_cnt == '1) ? r_err_cnt
                                         : r_err_cnt + ERR_CNT_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_bin_nxt       = r_bin;
        w_bin_valid_nxt = 1'b0;
        w_dir_nxt       = r_dir;
        w_step_err_nxt  = 1'b0;
        w_err_cnt_nxt   = r_err_cnt;
        w_good_nxt      = r_good;
        if (w_valid) begin
            w_bin_nxt       = w_bin;
            w_bin_valid_nxt = 1'b1;
            w_dir_nxt       = w_step_dir;
            unique case (r_state)
                UNLOCKED: begin
                    w_dir_nxt   = DIR_HOLD;
                    w_good_nxt  = '0;
                    w_state_nxt = RESYNC;
                end
                RESYNC: begin
                    if (w_step_dir == DIR_ILLEGAL) begin
                        w_good_nxt     = '0;
                        w_step_err_nxt = 1'b1;
                        w_err_cnt_nxt  = w_err_inc;
                    end else if (w_step_dir != DIR_HOLD) begin
                        if (r_good == GW'(LOCK_CNT - 1)) begin
                            w_good_nxt  = '0;
                            w_state_nxt = TRACK;
                        end else begin
                            w_good_nxt = r_good + GW'(1);
                        end
                    end
                end
                TRACK: begin
                    if (w_step_dir == DIR_ILLEGAL) begin
                        w_good_nxt     = '0;
                        w_step_err_nxt = 1'b1;
                        w_err_cnt_nxt  = w_err_inc;
                        w_state_nxt    = RESYNC;
                    end
                end
                default: begin
                    w_good_nxt  = '0;
                    w_state_nxt = UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= UNLOCKED;
            r_bin       <= '0;
            r_bin_valid <= 1'b0;
            r_dir       <= DIR_HOLD;
            r_step_err  <= 1'b0;
            r_err_cnt   <= '0;
            r_good      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bin       <= w_bin_nxt;
            r_bin_valid <= w_bin_valid_nxt;
            r_dir       <= w_dir_nxt;
            r_step_err  <= w_step_err_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_good      <= w_good_nxt;
        end
    end

    assign o_bin       = r_bin;
    assign o_bin_valid = r_bin_valid;
    assign o_dir       = r_dir;
    assign o_step_err  = r_step_err;
    assign o_err_cnt   = r_err_cnt;
    assign o_locked    = (r_state == TRACK);

endmodule

// File: tb/tb_gray_rx_monitor.sv
// Self-checking bench for gray_rx_monitor (default and 2-bit error counter).
// Honors GRAY_RX_SYNC_EN by shifting expectations by the synchronizer delay.
module tb_gray_rx_monitor;

    localparam int W    = 4;
    localparam int N    = 16;
    localparam int LOCK = 3;
`ifdef GRAY_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] i_gray = '0;
    logic         i_valid = 1'b0;

    logic [W-1:0] o_bin;
    logic         o_bin_valid;
    logic [1:0]   o_dir;
    logic         o_step_err;
    logic [7:0]   o_err_cnt;
    logic         o_locked;

    logic [W-1:0] s_bin;
    logic         s_bin_valid;
    logic [1:0]   s_dir;
    logic         s_step_err;
    logic [1:0]   s_err_cnt;
    logic         s_locked;

    gray_rx_monitor #(
        .WIDTH(W), .ERR_CNT_W(8), .LOCK_CNT(LOCK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_gray(i_gray), .i_valid(i_valid),
        .o_bin(o_bin), .o_bin_valid(o_bin_valid), .o_dir(o_dir),
        .o_step_err(o_step_err), .o_err_cnt(o_err_cnt),
        .o_locked(o_locked)
    );

    gray_rx_monitor #(
        .WIDTH(W), .ERR_CNT_W(2), .LOCK_CNT(LOCK)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_gray(i_gray), .i_valid(i_valid),
        .o_bin(s_bin), .o_bin_valid(s_bin_valid), .o_dir(s_dir),
        .o_step_err(s_step_err), .o_err_cnt(s_err_cnt),
        .o_locked(s_locked)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int m_have, m_bin, m_dir, m_bv, m_se;
    int m_err, m_err_s, m_good, m_locked;
    int tab [N];
    logic [W-1:0] q_g [$];
    logic         q_v [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_bin = 0; m_dir = 0; m_bv = 0; m_se = 0;
        m_err = 0; m_err_s = 0; m_good = 0; m_locked = 0;
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] g);
        int b, d;
        m_bv = 0;
        m_se = 0;
        if (v) begin
            b = tab[g];
            m_bv = 1;
            if (m_have == 0) begin
                m_have = 1;
                m_dir = 0;
            end else begin
                d = (b - m_bin + N) % N;
                if (d == 0) m_dir = 0;
                else if (d == 1) m_dir = 1;
                else if (d == N - 1) m_dir = 2;
                else m_dir = 3;
                if (m_dir == 3) begin
                    m_se = 1;
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    m_err_s = (m_err_s < 3) ? m_err_s + 1 : 3;
                    m_good = 0;
                    m_locked = 0;
                end else if (m_dir != 0 && m_locked == 0) begin
                    m_good++;
                    if (m_good >= LOCK) begin
                        m_locked = 1;
                        m_good = 0;
                    end
                end
            end
            m_bin = b;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".bin"}, 32'(o_bin), m_bin);
        chk({ph, ".bin_valid"}, 32'(o_bin_valid), m_bv);
        chk({ph, ".dir"}, 32'(o_dir), m_dir);
        chk({ph, ".step_err"}, 32'(o_step_err), m_se);
        chk({ph, ".err_cnt"}, 32'(o_err_cnt), m_err);
        chk({ph, ".locked"}, 32'(o_locked), m_locked);
        chk({ph, ".sat_err_cnt"}, 32'(s_err_cnt), m_err_s);
        chk({ph, ".sat_step_err"}, 32'(s_step_err), m_se);
    endtask

    task automatic cyc(input string ph, input logic v,
                       input logic [W-1:0] g);
        i_valid = v;
        i_gray = g;
        q_v.push_back(v);
        q_g.push_back(g);
        @(posedge clk);
        if (q_v.size() >= LAT) model_step(q_v.pop_front(), q_g.pop_front());
        else model_step(1'b0, '0);
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic bval(input string ph, input int b);
        logic [W-1:0] bb;
        bb = W'(b);
        cyc(ph, 1'b1, bb ^ (bb >> 1));
    endtask

    task automatic flush(input string ph);
        repeat (LAT - 1) cyc(ph, 1'b0, '0);
    endtask

    initial begin
        int cur, r;
        for (int i = 0; i < N; i++) tab[i ^ (i >> 1)] = i;
        model_reset();
        rst_n = 1'b1;
        #1000;
        check_all("reset");
        rst_n = 1'b0;

        for (int b = 0; b < N; b++) bval("seq", b);
        flush("seq");
        chk("seq_locked", 32'(o_locked), 1);
        chk("seq_err0", 32'(o_err_cnt), 0);

        bval("wrap_up", 0);
        bval("wrap_down", 15);
        bval("to0", 0);
        bval("to1", 1);
        bval("jump", 7);
        flush("jump");
        chk("jump_unlocked", 32'(o_locked), 0);
        bval("relock", 8);
        bval("relock", 9);
        bval("relock", 10);
        flush("relock");
        chk("relocked", 32'(o_locked), 1);

        for (int k = 0; k < 5; k++) bval("sat", (k % 2 == 0) ? 2 : 10);
        flush("sat");
        chk("sat_cnt3", 32'(s_err_cnt), 3);
        chk("main_cnt6", 32'(o_err_cnt), 6);

        for (int k = 0; k < 6; k++) begin
            cyc("hold", 1'b1, 4'b0011);
            cyc("gap", 1'b0, 4'b0110);
        end
        flush("hold");
        chk("hold_bin", 32'(o_bin), 2);
        chk("hold_dir", 32'(o_dir), 0);

        i_valid = 1'b1;
        i_gray = 4'b0010;
        #2;
        rst_n = 1'b1;
        #1;
        model_reset();
        q_v.delete();
        q_g.delete();
        check_all("midrst");
        chk("midrst_locked", 32'(o_locked), 0);
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;

        cur = 5;
        bval("first", cur);
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                cyc("rnd_gap", 1'b0, W'($urandom));
            end else begin
                if (r < 20) cur = cur;
                else if (r < 30) cur = int'($urandom_range(0, N - 1));
                else if (r < 65) cur = (cur + 1) % N;
                else cur = (cur + N - 1) % N;
                bval("rnd", cur);
            end
        end
        flush("rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
